hazard_scheduler: RTL

- Pipeline hazard controller for the 5-stage core; works alongside the EX/MEM operand-forwarding logic.
- Keeps a load scoreboard of destination registers whose loads are still outstanding on the system bus.
- Stalls the IF and ID stages and inserts a bubble into ID/EX when an ID-stage instruction reads a pending load destination.
- Sequences multi-cycle front-end flushes on taken branches.

---
 rtl/hazard_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/hazard_scheduler.sv
// Load-use hazard scoreboard and branch flush sequencer
// for the 5-stage core front end.
module hazard_scheduler #(
    parameter int NUM_REGS     = 32,
    parameter int MAX_PENDING  = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               inIdValid,
    input  logic [4:0]                         inIdRs,
    input  logic [4:0]                         inIdRt,
    input  logic                               inIdIsLoad,
    input  logic [4:0]                         inIdDest,
    input  logic                               inLoadRespValid,
    input  logic [4:0]                         inLoadRespDest,
    input  logic                               inBranchTaken,
    output logic                               outStallIf,
    output logic                               outStallId,
    output logic                               outBubbleEx,
    output logic                               outFlushFront,
    output logic [$clog2(MAX_PENDING+1)-1:0]   outPendingCount,
    output logic [NUM_REGS-1:0]                outBusyVector,
    output logic                               outScoreboardErr
);

    localparam int CW  = $clog2(MAX_PENDING + 1);
    localparam int FCW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0]  MAX_CNT    = CW'(MAX_PENDING);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
    localparam bit             MULTI      = (FLUSH_CYCLES > 1);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [FCW-1:0]  r_fcnt;
    logic [FCW-1:0]  w_fcnt_nxt;
    logic            w_flush;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       w_count_nxt;
    logic                r_err;

    logic w_haz_rs;
    logic w_haz_rt;
    logic w_haz_cap;
    logic w_haz;
    logic w_issue;
    logic w_resp_ok;
    logic w_resp_bad;

    // Flush FSM state and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Flush FSM next state; a branch during FLUSH restarts the window
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        w_flush     = 1'b0;
        unique case (r_state)
            RUN: begin
                w_flush = inBranchTaken;
                if (inBranchTaken && MULTI) begin
                    w_state_nxt = FLUSH;
                    w_fcnt_nxt  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                w_flush = 1'b1;
                if (inBranchTaken) begin
                    w_fcnt_nxt = FLUSH_LOAD;
                end else if (r_fcnt <= FCW'(1)) begin
                    w_state_nxt = RUN;
                    w_fcnt_nxt  = '0;
                end else begin
                    w_fcnt_nxt = r_fcnt - FCW'(1);
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_fcnt_nxt  = '0;
            end
        endcase
    end

    // Hazard detection against the registered scoreboard
    always_comb begin
        w_haz_rs   = r_busy[inIdRs] && (inIdRs != 5'd0);
        w_haz_rt   = r_busy[inIdRt] && (inIdRt != 5'd0);
        w_haz_cap  = inIdIsLoad && (r_count == MAX_CNT);
        w_haz      = inIdValid && (w_haz_rs || w_haz_rt || w_haz_cap);
        w_issue    = inIdValid && inIdIsLoad && !w_haz && !w_flush;
        w_resp_ok  = inLoadRespValid && (r_count != '0);
        w_resp_bad = inLoadRespValid && (r_count == '0);
    end

    // Scoreboard update; a same-register issue overrides the release
    always_comb begin
        w_busy_nxt  = r_busy;
        w_count_nxt = r_count;
        if (w_resp_ok) begin
            w_busy_nxt[inLoadRespDest] = 1'b0;
        end
        if (w_issue && (inIdDest != 5'd0)) begin
            w_busy_nxt[inIdDest] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
        if (w_issue && !w_resp_ok) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_issue && w_resp_ok) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Scoreboard and sticky error registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
            if (w_resp_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    // Outputs; combinational terms are forced low while reset is held
    always_comb begin
        outFlushFront    = reset_n && w_flush;
        outStallIf       = reset_n && w_haz && !w_flush;
        outStallId       = reset_n && w_haz && !w_flush;
        outBubbleEx      = reset_n && w_haz && !w_flush;
        outPendingCount  = r_count;
        outBusyVector    = r_busy;
        outScoreboardErr = r_err;
    end

endmodule
